// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative integer multiply/divide unit (RV32M/RV64M style).
//   One shift-add (multiply) or restoring-subtract (divide) step per cycle,
//   XLEN steps per operation. Divide-by-zero and signed overflow bypass the
//   iteration and complete one edge after accept.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start           request; accepted only in IDLE with flush low
//   funct3          000 MUL 001 MULH 010 MULHSU 011 MULHU
//                   100 DIV 101 DIVU 110 REM 111 REMU
//   op_a, op_b      rs1 / rs2 operands, latched at accept
//   tag_in          destination tag, latched at accept
//   flush           abort in-flight operation (beats start)
//   busy            unit occupied (state != IDLE)
//   done            one-cycle pulse, result/tag_out valid
//   result, tag_out registered outputs, held until the next completion
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nx;

    logic [CW-1:0]    cnt;
    logic [XLEN-1:0]  hi;      // product high half / partial remainder
    logic [XLEN-1:0]  lo;      // multiplier / dividend-quotient shift reg
    logic [XLEN-1:0]  dvs;     // multiplicand / divisor magnitude
    logic [2:0]       op_r;
    logic             neg_q;   // negate product or quotient at the end
    logic             neg_r;   // negate remainder at the end
    logic             fast;    // result already sitting in lo
    logic [TAG_W-1:0] tag_r;

    logic accept;
    assign accept = start && !flush && (state == IDLE);

    // ---------------- accept-time decode ----------------
    logic            is_div, div_signed, a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0] a_mag, b_mag, fast_val;

    always_comb begin
        is_div     = funct3[2];
        div_signed = funct3[2] && !funct3[0];
        a_neg      = op_a[XLEN-1] && (is_div ? div_signed
                                             : (funct3 == 3'b001 || funct3 == 3'b010));
        b_neg      = op_b[XLEN-1] && (is_div ? div_signed : (funct3 == 3'b001));
        a_mag      = a_neg ? -op_a : op_a;
        b_mag      = b_neg ? -op_b : op_b;
        div_zero   = is_div && (op_b == '0);
        ovf        = div_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        // funct3[1] distinguishes REM* from DIV*
        if (div_zero) fast_val = funct3[1] ? op_a : '1;
        else          fast_val = funct3[1] ? '0   : op_a;
    end

    // ---------------- one iteration ----------------
    logic [XLEN:0]     sum, trial;
    logic              ge;
    logic [XLEN-1:0]   nxt_hi, nxt_lo, quo, rem;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        // multiply: conditionally add, then shift {hi,lo} right by one
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
        // divide: shift next dividend bit into the remainder and trial-subtract
        trial = {hi, lo[XLEN-1]} - {1'b0, dvs};
        ge    = !trial[XLEN];
        if (op_r[2]) begin
            nxt_hi = ge ? trial[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]};
            nxt_lo = {lo[XLEN-2:0], ge};
        end else begin
            nxt_hi = sum[XLEN:1];
            nxt_lo = {sum[0], lo[XLEN-1:1]};
        end
        // sign fix-up applied on the edge that enters DONE
        prod   = {nxt_hi, nxt_lo};
        prod_s = neg_q ? -prod : prod;
        quo    = neg_q ? -nxt_lo : nxt_lo;
        rem    = neg_r ? -nxt_hi : nxt_hi;
        case (op_r)
            3'b000:                 final_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo;
            default:                final_res = rem;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CALC;
            CALC:    if (fast || cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            dvs     <= '0;
            op_r    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            fast    <= 1'b0;
            tag_r   <= '0;
            result  <= '0;
            tag_out <= '0;
        end else if (accept) begin
            cnt   <= CW'(XLEN-1);
            hi    <= '0;
            lo    <= (div_zero || ovf) ? fast_val : a_mag;
            dvs   <= b_mag;
            op_r  <= funct3;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            fast  <= div_zero || ovf;
            tag_r <= tag_in;
        end else if (state == CALC && !flush) begin
            if (fast) begin
                result  <= lo;
                tag_out <= tag_r;
            end else begin
                hi  <= nxt_hi;
                lo  <= nxt_lo;
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    result  <= final_res;
                    tag_out <= tag_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  tag_in;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  tag_out;

    int n_chk  = 0;
    int n_fail = 0;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .tag_in(tag_in), .flush(flush),
        .busy(busy), .done(done), .result(result), .tag_out(tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, wait for done, check latency/result/tag/busy, then
    // check the pulse drops and the unit returns to IDLE.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t,
                          input logic [31:0] exp, input int lat);
        int n;
        logic bz;
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b; tag_in = t;
        @(posedge clk); #1;
        // scramble inputs: the unit must use the latched copies
        start = 1'b0; op_a = 32'hDEADBEEF; op_b = 32'h0; tag_in = 5'h1F; funct3 = ~f;
        n = 0; bz = 1'b1;
        while (!done && n < 100) begin
            if (!busy) bz = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'(lat));
        chk({name, " result"}, {32'h0, result}, {32'h0, exp});
        chk({name, " tag"}, {59'h0, tag_out}, {59'h0, t});
        chk({name, " busy"}, {63'h0, bz & busy}, 64'h1);
        @(posedge clk); #1;
        chk({name, " done pulse"}, {62'h0, done, busy}, 64'h0);
    endtask

    initial begin
        int n, dcount;
        rst_n = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        tag_in = '0; flush = 1'b0;
        #12;
        chk("reset outputs", {busy, done, result, tag_out}, 64'h0);
        @(posedge clk); #2 rst_n = 1'b1;

        // first op lands on the first rising edge after release
        run_op("mul neg",   3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 32);
        run_op("mulhu ff",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 32);
        run_op("mulh ff",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000000, 32);
        run_op("mulhsu ff", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 32);
        run_op("mul shift", 3'b000, 32'h12345678, 32'h10,       5'd7,  32'h23456780, 32);
        run_op("mulh min",  3'b001, 32'h80000000, 32'h80000000, 5'd8,  32'h40000000, 32);
        run_op("div -7/2",  3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 32);
        run_op("rem -7/2",  3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 32);
        run_op("divu -7/2", 3'b101, 32'hFFFFFFF9, 32'd2,        5'd11, 32'h7FFFFFFC, 32);
        run_op("remu -7/2", 3'b111, 32'hFFFFFFF9, 32'd2,        5'd12, 32'h00000001, 32);
        run_op("div 7/-2",  3'b100, 32'd7,        32'hFFFFFFFE, 5'd13, 32'hFFFFFFFD, 32);
        run_op("rem 7/-2",  3'b110, 32'd7,        32'hFFFFFFFE, 5'd14, 32'h00000001, 32);
        run_op("div 5/0",   3'b100, 32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 1);
        run_op("rem 5/0",   3'b110, 32'd5,        32'd0,        5'd16, 32'h00000005, 1);
        run_op("divu 5/0",  3'b101, 32'd5,        32'd0,        5'd17, 32'hFFFFFFFF, 1);
        run_op("remu 5/0",  3'b111, 32'd5,        32'd0,        5'd18, 32'h00000005, 1);
        run_op("div ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1);
        run_op("rem ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h00000000, 1);

        // start while busy (mid-CALC and during DONE) must be ignored
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; tag_in = 5'd21;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; tag_in = 5'd1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        n = 7;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        chk("busy-start latency", 64'(n), 64'd32);
        chk("busy-start result", {32'h0, result}, 64'd14);
        chk("busy-start tag", {59'h0, tag_out}, 64'd21);
        start = 1'b1;                  // held across the DONE->IDLE edge
        @(posedge clk); #1 start = 1'b0;
        chk("start in DONE ignored", {63'h0, busy}, 64'h0);

        // flush on the 10th iteration edge
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; tag_in = 5'd22;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush idle", {62'h0, busy, done}, 64'h0);
        chk("flush keeps result", {27'h0, tag_out, result}, {27'h0, 5'd21, 32'd14});
        run_op("after flush", 3'b100, 32'd100, 32'd7, 5'd23, 32'd14, 32);

        // flush beats a simultaneous start
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd1; op_b = 32'd1;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        chk("flush over start", {63'h0, busy}, 64'h0);

        // async reset mid-CALC
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; tag_in = 5'd24;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset", {busy, done, result, tag_out}, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin @(posedge clk); #1; if (done) dcount++; end
        chk("no done after reset", 64'(dcount), 64'h0);

        // start on the first edge after a reset release
        rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        run_op("post-reset", 3'b000, 32'd6, 32'd7, 5'd25, 32'd42, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
